counter: RTL and testbench



---
 rtl/counter.sv | 52 +++++
 tb/tb_counter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter.sv
// ---------------------------------------------------------------------------
// counter
//   Free-running unsigned up-counter. It advances by one on every rising
//   clock edge and wraps to zero after the terminal value MAX_VALUE. A parent
//   block uses it as a cycle index or sequencing source.
//
// Parameters
//   WIDTH      bit width of the count (default 8)
//   MAX_VALUE  terminal count, legal range 1 .. 2^WIDTH-1 (default all ones)
//
// Ports
//   value  output [WIDTH-1:0]  current count, driven straight from a register
//   clk    input               rising-edge clock, the only clock of the block
//   reset  input               asynchronous, active-low; 0 holds count at 0
// ---------------------------------------------------------------------------
module counter #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}}
) (
    output logic [WIDTH-1:0] value,
    input  logic             clk,
    input  logic             reset
);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;

    // Next-count logic: wrap at the terminal value, otherwise increment.
    // A count above MAX_VALUE cannot be reached from reset; should one ever
    // appear it takes the increment path and wraps by natural overflow.
    always_comb begin
        count_next_s = count_r;
        if (count_r == MAX_VALUE) begin
            count_next_s = {WIDTH{1'b0}};
        end else begin
            count_next_s = count_r + WIDTH'(1'b1);
        end
    end

    // Count register: asynchronous clear dominates any coincident clock edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= {WIDTH{1'b0}};
        end else begin
            count_r <= count_next_s;
        end
    end

    // The output is the register itself, so no input reaches it combinationally.
    assign value = count_r;

endmodule

// File: tb/tb_counter.sv
// ---------------------------------------------------------------------------
// tb_counter
//   Self-checking bench for counter. Two instances share clock and reset:
//   the default 8-bit wrap-at-255 counter and a 4-bit wrap-at-9 counter.
//   A reference model pushes expected values into scoreboard queues whenever
//   stimulus is applied; the values are popped and compared once the DUT
//   outputs have settled, away from the clock edge.
// ---------------------------------------------------------------------------
module tb_counter;

    logic       clk;
    logic       reset;
    logic [7:0] value8;
    logic [3:0] value4;

    int total_cnt;
    int bad_cnt;

    // reference model state
    int model8;
    int model4;

    logic [31:0] exp_q8[$];
    logic [31:0] exp_q4[$];

    counter #(
        .WIDTH     (8),
        .MAX_VALUE (8'd255)
    ) u_dut8 (
        .value (value8),
        .clk   (clk),
        .reset (reset)
    );

    counter #(
        .WIDTH     (4),
        .MAX_VALUE (4'd9)
    ) u_dut4 (
        .value (value4),
        .clk   (clk),
        .reset (reset)
    );

    // single comparison point for the whole bench
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // push current model values as the expected next observation
    task automatic push_expected();
        exp_q8.push_back(32'(model8));
        exp_q4.push_back(32'(model4));
    endtask

    // pop the scoreboard and compare against both DUTs
    task automatic pop_compare(input string tag);
        logic [31:0] e8;
        logic [31:0] e4;
        if (exp_q8.size() == 0 || exp_q4.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e8 = exp_q8.pop_front();
            e4 = exp_q4.pop_front();
            check({tag, "_w8"}, {24'd0, value8}, e8);
            check({tag, "_w4"}, {28'd0, value4}, e4);
        end
    endtask

    // advance the model the way a rising edge should advance the counters
    task automatic model_edge();
        if (reset == 1'b1) begin
            model8 = (model8 == 255) ? 0 : model8 + 1;
            model4 = (model4 == 9)   ? 0 : model4 + 1;
        end else begin
            model8 = 0;
            model4 = 0;
        end
    endtask

    // one full clock period; outputs checked 1 time unit after the rise
    task automatic clock_edge(input string tag);
        clk = 1'b1;
        model_edge();
        push_expected();
        #1;
        pop_compare(tag);
        #4;
        clk = 1'b0;
        #5;
    endtask

    // apply reset low mid low-phase (no clock edge) and check the async clear
    task automatic assert_reset(input string tag);
        #2;
        reset  = 1'b0;
        model8 = 0;
        model4 = 0;
        push_expected();
        #1;
        pop_compare(tag);
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        clk       = 1'b0;
        reset     = 1'b1;
        model8    = 0;
        model4    = 0;

        // async reset with the clock stopped, then three edges
        #3;
        assert_reset("async_rst");
        #3;
        reset = 1'b1;
        #1;
        for (int i = 1; i <= 3; i++) begin
            clock_edge($sformatf("post_rst_e%0d", i));
        end
        check("post_rst_direct", {24'd0, value8}, 32'd3);

        // free run and wrap from a fresh reset
        assert_reset("wrap_rst");
        #2;
        reset = 1'b1;
        #5;
        for (int i = 1; i <= 260; i++) begin
            clock_edge($sformatf("run_e%0d", i));
            if (i == 255) check("edge255", {24'd0, value8}, 32'd255);
            if (i == 256) check("edge256", {24'd0, value8}, 32'd0);
            if (i == 260) check("edge260", {24'd0, value8}, 32'd4);
            if (value4 > 4'd9) check("w4_bound", {28'd0, value4}, 32'd9);
        end

        // mid-count reset: count to 10, reset between edges, hold, release
        assert_reset("mid_pre_rst");
        #2;
        reset = 1'b1;
        #5;
        for (int i = 1; i <= 10; i++) begin
            clock_edge($sformatf("mid_count_e%0d", i));
        end
        check("mid_at10", {24'd0, value8}, 32'd10);
        assert_reset("mid_rst");
        #7;
        for (int i = 1; i <= 5; i++) begin
            clock_edge($sformatf("mid_hold_e%0d", i));
        end
        reset = 1'b1;
        #5;
        clock_edge("mid_release");
        check("mid_release_one", {24'd0, value8}, 32'd1);

        // reset assertion coincident with a rising edge: reset must win
        for (int i = 1; i <= 5; i++) begin
            clock_edge($sformatf("coinc_pre_e%0d", i));
        end
        reset = 1'b0;
        clk   = 1'b1;
        model_edge();
        push_expected();
        #1;
        pop_compare("coinc_edge");
        check("coinc_zero", {24'd0, value8}, 32'd0);
        #4;
        clk = 1'b0;
        #2;
        reset = 1'b1;
        #3;
        clock_edge("coinc_release");

        // short reset pulse with no clock edge inside it
        for (int i = 1; i <= 3; i++) begin
            clock_edge($sformatf("pulse_pre_e%0d", i));
        end
        assert_reset("pulse_low");
        #1;
        reset = 1'b1;
        push_expected();
        #1;
        pop_compare("pulse_after");
        #2;
        clock_edge("pulse_next");
        check("pulse_next_one", {24'd0, value8}, 32'd1);

        if (exp_q8.size() != 0 || exp_q4.size() != 0) begin
            check("queue_drained", 32'(exp_q8.size() + exp_q4.size()), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
